// File: rtl/lifo_stack_pkg.sv
// Shared state encoding for lifo_stack and its verification environment.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_NORMAL = 2'b01,
    ST_ERROR  = 2'b10,
    ST_FULL   = 2'b11
  } state_e;

  // State to resume in when an error is cleared, based on the frozen occupancy.
  function automatic state_e clr_target(input logic is_empty, input logic is_full);
    if (is_empty) begin
      return ST_EMPTY;
    end else if (is_full) begin
      return ST_FULL;
    end else begin
      return ST_NORMAL;
    end
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: DEPTH x WIDTH register array, one write port, one combinational read port.
module lifo_stack_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next array contents: single-entry update when enabled.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Array storage; contents are don't-care after reset, so no reset is applied.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read; the caller keeps raddr inside 0..DEPTH-1.
  assign rd_data_c = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: data-carrying LIFO with replace (push+pop), sticky error and clr_err.
// Optional almost_full/almost_empty watermarks when LIFO_STACK_WATERMARK_EN is defined.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned CW      = $clog2(DEPTH + 1),
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             error,
  output logic [1:0]       state
`ifdef LIFO_STACK_WATERMARK_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  // Parameter sanity checks at elaboration.
  if (WIDTH < 1) begin : g_chk_width
    $error("lifo_stack: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("lifo_stack: DEPTH must be >= 2");
  end
`ifdef LIFO_STACK_WATERMARK_EN
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_chk_levels
    $error("lifo_stack: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end
`else
  // Watermark levels are accepted but have no effect in this build.
  if ((AF_LEVEL == 0) && (AE_LEVEL == 0)) begin : g_lvl_ignored
  end
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             error_q, error_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rd_data;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    cnt_dec;

  assign cnt_inc = count_q + CW'(1);
  assign cnt_dec = count_q - CW'(1);

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (wr_data),
    .raddr     (mem_raddr),
    .rd_data_c (mem_rd_data)
  );

  // Next state, count, top word and array write control.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    top_d     = top_q;
    mem_we    = 1'b0;
    mem_waddr = AW'(count_q);
    // Entry below the current top, i.e. the new top after a pop.
    mem_raddr = (count_q >= CW'(2)) ? AW'(count_q - CW'(2)) : '0;

    unique case (state_q)
      ST_EMPTY: begin
        if (pop) begin
          state_d = ST_ERROR;
        end else if (push) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          count_d   = CW'(1);
          top_d     = wr_data;
          state_d   = ST_NORMAL;
        end
      end
      ST_NORMAL, ST_FULL: begin
        if (push && pop) begin
          // Replace top: count and state unchanged.
          mem_we    = 1'b1;
          mem_waddr = AW'(cnt_dec);
          top_d     = wr_data;
        end else if (push) begin
          if (state_q == ST_FULL) begin
            state_d = ST_ERROR;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = AW'(count_q);
            count_d   = cnt_inc;
            top_d     = wr_data;
            state_d   = (cnt_inc == CW'(DEPTH)) ? ST_FULL : ST_NORMAL;
          end
        end else if (pop) begin
          count_d = cnt_dec;
          if (cnt_dec == '0) begin
            top_d   = '0;
            state_d = ST_EMPTY;
          end else begin
            top_d   = mem_rd_data;
            state_d = ST_NORMAL;
          end
        end
      end
      ST_ERROR: begin
        if (clr_err) begin
          state_d = clr_target(count_q == '0, count_q == CW'(DEPTH));
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    error_d = (state_d == ST_ERROR);
  end

  // State, count, top word and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      top_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      top_q   <= top_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      error_q <= error_d;
    end
  end

  assign top_data = top_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign error    = error_q;
  assign state    = state_q;

`ifdef LIFO_STACK_WATERMARK_EN
  logic af_q, af_d;
  logic ae_q, ae_d;

  // Watermarks follow the next count; count is frozen in ERROR, so they freeze too.
  always_comb begin
    af_d = (count_d >= CW'(AF_LEVEL));
    ae_d = (count_d <= CW'(AE_LEVEL));
  end

  // Watermark flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= af_d;
      ae_q <= ae_d;
    end
  end

  assign almost_full  = af_q;
  assign almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: table-driven directed bench for lifo_stack (DEPTH=8, WIDTH=8).
module tb_lifo_stack;
  import lifo_stack_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset_n;
  logic             push;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             error;
  logic [1:0]       state;
`ifdef LIFO_STACK_WATERMARK_EN
  logic             almost_full;
  logic             almost_empty;
`endif

  lifo_stack #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .clr_err  (clr_err),
    .wr_data  (wr_data),
    .top_data (top_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .error    (error),
    .state    (state)
`ifdef LIFO_STACK_WATERMARK_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             push;
    logic             pop;
    logic             clr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    cnt;
    logic [1:0]       st;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full output check against an expected top/count/state; flags derived from those.
  task automatic check_all(input string tag, input logic [WIDTH-1:0] etop,
                           input logic [CW-1:0] ecnt, input logic [1:0] est);
    check({tag, " top_data"}, 32'(top_data), 32'(etop));
    check({tag, " count"},    32'(count),    32'(ecnt));
    check({tag, " state"},    32'(state),    32'(est));
    check({tag, " empty"},    32'(empty),    32'(ecnt == '0));
    check({tag, " full"},     32'(full),     32'(ecnt == CW'(DEPTH)));
    check({tag, " error"},    32'(error),    32'(est == 2'(ST_ERROR)));
`ifdef LIFO_STACK_WATERMARK_EN
    check({tag, " almost_full"},  32'(almost_full),  32'(ecnt >= CW'(6)));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(ecnt <= CW'(2)));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic p, input logic q, input logic c, input logic [WIDTH-1:0] d);
    @(negedge clk);
    push    = p;
    pop     = q;
    clr_err = c;
    wr_data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic p, input logic q, input logic c,
                              input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] t,
                              input logic [CW-1:0] n, input logic [1:0] s);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.wd = d; v.top = t; v.cnt = n; v.st = s;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; wr_data = '0;
    reset_n = 1'b0;

    // Basic push/pop and replace.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h11, 8'h11, 4'd1, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h22, 8'h22, 4'd2, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h33, 8'h33, 4'd3, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h55, 8'h55, 4'd3, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 4'd2, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 4'd1, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 2'(ST_EMPTY)));
    // Underflow, ignored push in ERROR, clear.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 2'(ST_ERROR)));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 4'd0, 2'(ST_ERROR)));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 2'(ST_EMPTY)));
    // Replace at EMPTY is an underflow.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h99, 8'h00, 4'd0, 2'(ST_ERROR)));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 2'(ST_EMPTY)));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 2'(ST_EMPTY)));
    // Fill to DEPTH.
    for (int i = 1; i <= 8; i++) begin
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'(i), 8'(i), 4'(i),
                        (i == 8) ? 2'(ST_FULL) : 2'(ST_NORMAL)));
    end
    // Replace at FULL, overflow, frozen ERROR, clear back to FULL.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'hAA, 8'hAA, 4'd8, 2'(ST_FULL)));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h09, 8'hAA, 4'd8, 2'(ST_ERROR)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'hAA, 4'd8, 2'(ST_ERROR)));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 4'd8, 2'(ST_FULL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 4'd7, 2'(ST_NORMAL)));
    // clr_err outside ERROR is ignored; push completes normally.
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'h5A, 8'h5A, 4'd8, 2'(ST_FULL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 4'd7, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h06, 4'd6, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 4'd5, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 4'd4, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 4'd3, 2'(ST_NORMAL)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 4'd2, 2'(ST_NORMAL)));

    // Reset values with no clock edge needed.
    #12;
    check_all("reset", 8'h00, 4'd0, 2'(ST_EMPTY));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].wd);
      check_all($sformatf("vec%0d", i), vecs[i].top, vecs[i].cnt, vecs[i].st);
    end

    // Asynchronous reset in the middle of a push stream (count is 2 here).
    step(1'b1, 1'b0, 1'b0, 8'hC0);
    check_all("stream0", 8'hC0, 4'd3, 2'(ST_NORMAL));
    step(1'b1, 1'b0, 1'b0, 8'hC1);
    check_all("stream1", 8'hC1, 4'd4, 2'(ST_NORMAL));
    #3;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 4'd0, 2'(ST_EMPTY));
    @(posedge clk);
    #1;
    check_all("rst_hold", 8'h00, 4'd0, 2'(ST_EMPTY));
    @(negedge clk);
    reset_n = 1'b1;
    push = 1'b0;

    // After reset the stack is empty: popping underflows, push restarts from entry 0.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_all("post_rst_pop", 8'h00, 4'd0, 2'(ST_ERROR));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_all("post_rst_clr", 8'h00, 4'd0, 2'(ST_EMPTY));

    // Watermark ramp: 6 pushes then 4 pops.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      check_all($sformatf("wm_push%0d", i), 8'(8'h40 + i), 4'(i), 2'(ST_NORMAL));
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check_all($sformatf("wm_pop%0d", i), 8'(8'h46 - i), 4'(6 - i), 2'(ST_NORMAL));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_all("idle_hold", 8'h42, 4'd2, 2'(ST_NORMAL));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised data-carrying LIFO stack: the next-generation stack controller. It stores WIDTH-bit words up to DEPTH entries and exposes the top-of-stack word, occupancy and status flags. It adds same-cycle push+pop (replace top) and a sticky error state with explicit clear. It sits between a producer/consumer pair that needs last-in-first-out ordering, e.g. a return-address or operand stack.

## Interface
- WIDTH, 8: data word width in bits, ≥1
- DEPTH, 8: number of entries, ≥2
- AF_LEVEL, 6: almost-full threshold in entries; used only with the watermark option
- AE_LEVEL, 2: almost-empty threshold in entries; used only with the watermark option
- clk  input  1  clock; all state changes on its rising edge
- reset_n  input  1  asynchronous active-low reset
- push  input  1  push wr_data this cycle
- pop  input  1  pop the top entry this cycle
- clr_err  input  1  leave ERROR state; synchronous, single-cycle pulse
- wr_data  input  WIDTH  word to push
- top_data  output  WIDTH  current top-of-stack word; 0 when empty
- count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- error  output  1  state == ERROR
- state  output  2  EMPTY=2'b00, NORMAL=2'b01, FULL=2'b11, ERROR=2'b10
- almost_full, almost_empty  output  1 each  present only with LIFO_STACK_WATERMARK_EN

## Operation
- Storage: DEPTH×WIDTH register array. Entry i is valid for i < count. The top is entry count-1.
- States and transitions, evaluated on each edge:
  - EMPTY, push only → NORMAL; or FULL if DEPTH==1 (not allowed, since DEPTH ≥2).
  - EMPTY, pop (with or without push) → ERROR (underflow).
  - NORMAL, push only: count+1; go to FULL when the new count == DEPTH.
  - NORMAL, pop only: count-1; go to EMPTY when the new count == 0.
  - NORMAL or FULL, push+pop: replace. Entry count-1 ← wr_data. count and state are unchanged. This is not an error.
  - FULL, push only → ERROR (overflow). FULL, pop only → NORMAL, count-1.
  - Neither push nor pop: hold.
  - ERROR: push and pop are ignored, and contents and count are frozen. clr_err → EMPTY if count==0, FULL if count==DEPTH, otherwise NORMAL. clr_err outside ERROR has no effect.
- An erroring operation never modifies the array or count.
- top_data reflects the post-edge contents:
  - after a push or replace, it is the word just written;
  - after a pop, it is the old entry count-2;
  - when empty, it is 0.
- empty, full, error and count are decoded from registered state and count, so they are glitch-free and exactly consistent with each other.

## Timing
- Reset (reset_n low, asynchronous): state=EMPTY, count=0, top_data=0, empty=1, full=0, error=0, almost_full=0, almost_empty=1. Array contents are don't-care. Reset deassertion is synchronised externally.
- Reset during any operation aborts that operation. The stack is empty afterwards.
- Latency: an operation sampled at edge N is visible on all outputs immediately after edge N. There are no extra pipeline stages, and full asserts in the same cycle count reaches DEPTH.
- Back-to-back push/pop is supported every cycle. There is no ready/valid handshake; the requester must not push when full or pop when empty unless it is doing a replace.
- Count arithmetic uses $clog2(DEPTH+1) bits. Wrap-around cannot occur because boundary operations go to ERROR instead.

## Configuration
- LIFO_STACK_WATERMARK_EN defined:
  - almost_full = (count ≥ AF_LEVEL) and almost_empty = (count ≤ AE_LEVEL). Both are registered alongside count and are updated in the same cycle.
  - They are frozen while in ERROR.
  - Requires AE_LEVEL < AF_LEVEL ≤ DEPTH; check this at elaboration.
- Undefined: the almost_full and almost_empty ports and logic are absent, and AF_LEVEL and AE_LEVEL are unused.

## Structure
- Shared package lifo_stack_pkg holds the 2-bit state typedef and the EMPTY/NORMAL/FULL/ERROR constants, so the verification environment and future stack variants use the same encoding.
- Sub-module lifo_stack_mem: the register array with a write port (index, data, enable) and a combinational read of index count-1 / count-2. The top level owns the FSM, count and flags.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 → count=3, top_data=0x33, state=NORMAL. Pop twice → top_data=0x11, count=1.
- Push DEPTH=8 words 0x01..0x08 → full=1 and state=FULL on the 8th edge. One more push → error=1, count=8, top_data=0x08.
- From EMPTY, pop → ERROR, count=0. Push while in ERROR → ignored. Pulse clr_err → EMPTY.
- With count=3 and top=0x33, push+pop with wr_data=0x55 → top_data=0x55, count=3, no error. Same operation at FULL → stays FULL. Push+pop at EMPTY → ERROR.
- Assert reset_n low mid-cycle during a stream of pushes → outputs return to reset values immediately, with no clock edge needed.
- With LIFO_STACK_WATERMARK_EN, AF_LEVEL=6, AE_LEVEL=2: push 6 words → almost_full rises on the 6th edge. Pop 4 → almost_empty rises when count=2.
